// File: rtl/csr_uart_fifo.sv
// Buffered 8N1 UART on the CSR bus: DATA/CTRL/STATUS registers, TX and RX FIFOs,
// programmable baud divisor, sticky RX error flags and an RX-not-empty interrupt.
module csr_uart_fifo #(
    parameter logic [11:0] BASE_ADDR  = 12'hBC0,
    parameter int unsigned CLOCK_RATE = 12_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned TX_DEPTH   = 8,
    parameter int unsigned RX_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        read_i,
    input  logic [2:0]  modify_i,
    input  logic [31:0] wdata_i,
    input  logic [11:0] addr_i,
    output logic [31:0] rdata_o,
    output logic        valid_o,
    input  logic        rx_i,
    output logic        tx_o,
    output logic        irq_rx_o,
    output logic        avoid_warning_o
);

    localparam logic [15:0]  DivRst = 16'(CLOCK_RATE / BAUD_RATE - 1);
    localparam int unsigned  TxAw   = $clog2(TX_DEPTH);
    localparam int unsigned  RxAw   = $clog2(RX_DEPTH);
    localparam logic [TxAw:0] TxFullLvl = TX_DEPTH[TxAw:0];
    localparam logic [RxAw:0] RxFullLvl = RX_DEPTH[RxAw:0];

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_st_e;

    logic        sel_data_q, sel_ctrl_q, sel_status_q;
    logic [15:0] div_q;
    logic        irq_en_q;
    logic [16:0] ctrl_d;
    logic [31:0] rdata_q, rdata_d;
    logic        valid_q, irq_q, overrun_q, frame_err_q;

    // TX path state
    logic [7:0]      tx_mem_q [TX_DEPTH];
    logic [TxAw-1:0] tx_wp_q, tx_rp_q;
    logic [TxAw:0]   tx_lvl_q;
    uart_st_e        tx_st_q;
    logic [15:0]     tx_cnt_q, tx_div_q;
    logic [2:0]      tx_bit_q;
    logic [7:0]      tx_sh_q;
    logic            tx_q;

    // RX path state
    logic [7:0]      rx_mem_q [RX_DEPTH];
    logic [RxAw-1:0] rx_wp_q, rx_rp_q;
    logic [RxAw:0]   rx_lvl_q;
    uart_st_e        rx_st_q;
    logic [15:0]     rx_cnt_q, rx_div_q;
    logic [2:0]      rx_bit_q;
    logic [7:0]      rx_sh_q;
    logic            rx_s1_q, rx_s2_q;

    logic        data_wr, data_pop, data_clr;
    logic        tx_full, tx_push, tx_pop, tx_bit_end;
    logic        rx_full, rx_empty, rx_push, rx_pop, rx_stop_smp;
    logic [15:0] div_eff, rx_half_m1;
    logic [7:0]  rx_head, tx_lvl8, rx_lvl8;

    assign data_wr  = sel_data_q && (modify_i == 3'b001);
    assign data_pop = sel_data_q && (modify_i == 3'b010);
    assign data_clr = sel_data_q && (modify_i == 3'b011);

    assign div_eff    = (div_q < 16'd3) ? 16'd3 : div_q;
    assign tx_full    = (tx_lvl_q == TxFullLvl);
    assign tx_push    = data_wr && !tx_full;
    assign tx_bit_end = (tx_cnt_q == tx_div_q);
    // The FIFO is read both from idle and at the end of a stop bit, so frames run back-to-back.
    assign tx_pop     = (tx_lvl_q != '0) &&
                        ((tx_st_q == StIdle) || ((tx_st_q == StStop) && tx_bit_end));

    assign rx_full     = (rx_lvl_q == RxFullLvl);
    assign rx_empty    = (rx_lvl_q == '0);
    assign rx_stop_smp = (rx_st_q == StStop) && (rx_cnt_q == rx_div_q);
    assign rx_push     = rx_stop_smp && !rx_full;
    assign rx_pop      = data_pop && !rx_empty;
    assign rx_head     = rx_empty ? 8'h00 : rx_mem_q[rx_rp_q];
    // (DIV+1)/2 - 1, valid because the latched divisor is never below 3
    assign rx_half_m1  = (rx_div_q - 16'd1) >> 1;

    always_comb begin
        tx_lvl8 = '0;
        rx_lvl8 = '0;
        tx_lvl8[TxAw:0] = tx_lvl_q;
        rx_lvl8[RxAw:0] = rx_lvl_q;
    end

    always_comb begin
        ctrl_d = {irq_en_q, div_q};
        if (sel_ctrl_q) begin
            case (modify_i)
                3'b001:  ctrl_d = wdata_i[16:0];
                3'b010:  ctrl_d = ctrl_d | wdata_i[16:0];
                3'b011:  ctrl_d = ctrl_d & ~wdata_i[16:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata_d = '0;
        if (sel_data_q) begin
            rdata_d = {20'b0, frame_err_q, overrun_q, tx_full, rx_empty, rx_head};
        end else if (sel_ctrl_q) begin
            rdata_d = {15'b0, irq_en_q, div_q};
        end else if (sel_status_q) begin
            rdata_d = {16'b0, tx_lvl8, rx_lvl8};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sel_data_q   <= 1'b0;
            sel_ctrl_q   <= 1'b0;
            sel_status_q <= 1'b0;
            div_q        <= DivRst;
            irq_en_q     <= 1'b0;
            rdata_q      <= '0;
            valid_q      <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            sel_data_q   <= (addr_i == BASE_ADDR);
            sel_ctrl_q   <= (addr_i == BASE_ADDR + 12'd1);
            sel_status_q <= (addr_i == BASE_ADDR + 12'd2);
            {irq_en_q, div_q} <= ctrl_d;
            rdata_q      <= rdata_d;
            valid_q      <= sel_data_q || sel_ctrl_q || sel_status_q;
            irq_q        <= irq_en_q && !rx_empty;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wp_q] <= wdata_i[7:0];
        if (rx_push) rx_mem_q[rx_wp_q] <= rx_sh_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_wp_q     <= '0;
            tx_rp_q     <= '0;
            tx_lvl_q    <= '0;
            rx_wp_q     <= '0;
            rx_rp_q     <= '0;
            rx_lvl_q    <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
            if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
            if (tx_push && !tx_pop)      tx_lvl_q <= tx_lvl_q + 1'b1;
            else if (!tx_push && tx_pop) tx_lvl_q <= tx_lvl_q - 1'b1;
            if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
            if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
            if (rx_push && !rx_pop)      rx_lvl_q <= rx_lvl_q + 1'b1;
            else if (!rx_push && rx_pop) rx_lvl_q <= rx_lvl_q - 1'b1;
            // A new error in the same cycle as a clear wins, so no event is lost.
            if (data_clr) begin
                overrun_q   <= 1'b0;
                frame_err_q <= 1'b0;
            end
            if (rx_stop_smp && rx_full) overrun_q   <= 1'b1;
            if (rx_stop_smp && !rx_s2_q) frame_err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_st_q  <= StIdle;
            tx_cnt_q <= '0;
            tx_div_q <= DivRst;
            tx_bit_q <= '0;
            tx_sh_q  <= '0;
            tx_q     <= 1'b1;
        end else begin
            tx_cnt_q <= tx_bit_end ? 16'd0 : tx_cnt_q + 16'd1;
            if (tx_bit_end) tx_div_q <= div_eff;
            case (tx_st_q)
                StIdle: begin
                    tx_cnt_q <= '0;
                    if (tx_pop) begin
                        tx_st_q  <= StStart;
                        tx_sh_q  <= tx_mem_q[tx_rp_q];
                        tx_div_q <= div_eff;
                        tx_q     <= 1'b0;
                    end
                end
                StStart: if (tx_bit_end) begin
                    tx_st_q  <= StData;
                    tx_bit_q <= '0;
                    tx_q     <= tx_sh_q[0];
                end
                StData: if (tx_bit_end) begin
                    if (tx_bit_q == 3'd7) begin
                        tx_st_q <= StStop;
                        tx_q    <= 1'b1;
                    end else begin
                        tx_bit_q <= tx_bit_q + 3'd1;
                        tx_sh_q  <= tx_sh_q >> 1;
                        tx_q     <= tx_sh_q[1];
                    end
                end
                default: if (tx_bit_end) begin
                    if (tx_pop) begin
                        tx_st_q <= StStart;
                        tx_sh_q <= tx_mem_q[tx_rp_q];
                        tx_q    <= 1'b0;
                    end else begin
                        tx_st_q <= StIdle;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_s1_q  <= 1'b1;
            rx_s2_q  <= 1'b1;
            rx_st_q  <= StIdle;
            rx_cnt_q <= '0;
            rx_div_q <= DivRst;
            rx_bit_q <= '0;
            rx_sh_q  <= '0;
        end else begin
            rx_s1_q  <= rx_i;
            rx_s2_q  <= rx_s1_q;
            rx_cnt_q <= rx_cnt_q + 16'd1;
            case (rx_st_q)
                StIdle: begin
                    rx_cnt_q <= '0;
                    if (!rx_s2_q) begin
                        rx_st_q  <= StStart;
                        rx_div_q <= div_eff;
                    end
                end
                StStart: if (rx_cnt_q == rx_half_m1) begin
                    rx_cnt_q <= '0;
                    rx_bit_q <= '0;
                    rx_st_q  <= rx_s2_q ? StIdle : StData;
                end
                StData: if (rx_cnt_q == rx_div_q) begin
                    rx_cnt_q <= '0;
                    rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_st_q <= StStop;
                    else                  rx_bit_q <= rx_bit_q + 3'd1;
                end
                default: if (rx_stop_smp) begin
                    rx_cnt_q <= '0;
                    rx_st_q  <= StIdle;
                end
            endcase
        end
    end

    assign rdata_o         = rdata_q;
    assign valid_o         = valid_q;
    assign tx_o            = tx_q;
    assign irq_rx_o        = irq_q;
    assign avoid_warning_o = read_i | (|wdata_i[31:17]);

endmodule

// File: tb/tb_csr_uart_fifo.sv
// Directed bench for csr_uart_fifo at 1 MHz / 100 kBd (DIV 9, 10 cycles per bit).
module tb_csr_uart_fifo;

    localparam logic [11:0] ADATA = 12'hBC0;
    localparam logic [11:0] ACTRL = 12'hBC1;
    localparam logic [11:0] ASTAT = 12'hBC2;
    localparam logic [2:0]  MNONE = 3'b000;
    localparam logic [2:0]  MWR   = 3'b001;
    localparam logic [2:0]  MSET  = 3'b010;
    localparam logic [2:0]  MCLR  = 3'b011;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        read_i = 1'b0;
    logic [2:0]  modify_i = '0;
    logic [31:0] wdata_i = '0;
    logic [11:0] addr_i = '0;
    logic        rx_i = 1'b1;
    logic [31:0] rdata_o;
    logic        valid_o, tx_o, irq_rx_o, avoid_warning_o;

    int total = 0;
    int bad = 0;
    logic tx_samp [0:1023];

    csr_uart_fifo #(
        .BASE_ADDR (12'hBC0),
        .CLOCK_RATE(1_000_000),
        .BAUD_RATE (100_000),
        .TX_DEPTH  (8),
        .RX_DEPTH  (8)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .read_i         (read_i),
        .modify_i       (modify_i),
        .wdata_i        (wdata_i),
        .addr_i         (addr_i),
        .rdata_o        (rdata_o),
        .valid_o        (valid_o),
        .rx_i           (rx_i),
        .tx_o           (tx_o),
        .irq_rx_o       (irq_rx_o),
        .avoid_warning_o(avoid_warning_o)
    );

    always #5 clk = ~clk;

    // Address in D, modify in E, read data sampled the cycle after E.
    task automatic csr(input logic [11:0] a, input logic [2:0] m, input logic [31:0] wd,
                       output logic [31:0] rd, output logic v);
        @(negedge clk);
        addr_i = a;
        modify_i = MNONE;
        @(negedge clk);
        addr_i = '0;
        modify_i = m;
        wdata_i = wd;
        @(negedge clk);
        rd = rdata_o;
        v = valid_o;
        modify_i = MNONE;
        wdata_i = '0;
    endtask

    task automatic capture_tx(input int n, output bit found);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_o === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        if (found) begin
            tx_samp[0] = tx_o;
            for (int k = 1; k < n; k++) begin
                @(negedge clk);
                tx_samp[k] = tx_o;
            end
        end
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop_b, input int per);
        logic [9:0] fr;
        fr = {stop_b, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx_i = fr[i];
            repeat (per - 1) @(negedge clk);
        end
        @(negedge clk);
        rx_i = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic v;
        rstn = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (tx_o !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", tx_o); end
        total++; if (rdata_o !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", rdata_o); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid_o); end
        total++; if (irq_rx_o !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", irq_rx_o); end
        rstn = 1'b1;
        csr(ACTRL, MNONE, 32'h0, rd, v);
        total++; if (rd !== 32'h9) begin bad++; $display("FAIL reset_ctrl got=%h want=9", rd); end
        total++; if (v !== 1'b1) begin bad++; $display("FAIL reset_ctrl_valid got=%b want=1", v); end
        @(negedge clk);
        total++; if (valid_o !== 1'b0 || rdata_o !== 32'h0) begin
            bad++; $display("FAIL unaddressed got valid=%b rdata=%h want 0/0", valid_o, rdata_o);
        end
        csr(ADATA, MNONE, 32'h0, rd, v);
        total++; if (rd !== 32'h100) begin bad++; $display("FAIL reset_data got=%h want=100", rd); end
        csr(ASTAT, MWR, 32'hFFFF_FFFF, rd, v);
        csr(ASTAT, MNONE, 32'h0, rd, v);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL status_ro got=%h want=0", rd); end
        read_i = 1'b1;
        #1;
        total++; if (avoid_warning_o !== 1'b1) begin bad++; $display("FAIL avoid_rd got=%b want=1", avoid_warning_o); end
        read_i = 1'b0;
        wdata_i = 32'h0002_0000;
        #1;
        total++; if (avoid_warning_o !== 1'b1) begin bad++; $display("FAIL avoid_wd got=%b want=1", avoid_warning_o); end
        wdata_i = '0;
        #1;
        total++; if (avoid_warning_o !== 1'b0) begin bad++; $display("FAIL avoid_idle got=%b want=0", avoid_warning_o); end
    endtask

    task automatic test_tx_single();
        logic [31:0] rd;
        logic v;
        bit found;
        logic [10:0] fr;
        csr(ADATA, MWR, 32'h55, rd, v);
        capture_tx(110, found);
        total++;
        if (!found) begin
            bad++; $display("FAIL tx55_start got=no start want=start bit");
        end else begin
            fr = {1'b1, 1'b1, 8'h55, 1'b0};
            for (int i = 0; i < 11; i++) begin
                logic ok;
                ok = 1'b1;
                for (int s = 0; s < 10; s++) if (tx_samp[i*10+s] !== fr[i]) ok = 1'b0;
                if (i > 0) total++;
                if (!ok) begin bad++; $display("FAIL tx55_bit%0d got=%b.. want=%b", i, tx_samp[i*10], fr[i]); end
            end
        end
    endtask

    task automatic test_tx_fill();
        logic [31:0] rd;
        logic v;
        bit found;
        fork
            begin
                for (int i = 1; i <= 9; i++) csr(ADATA, MWR, i, rd, v);
                csr(ASTAT, MNONE, 32'h0, rd, v);
                total++; if (rd !== 32'h0800) begin bad++; $display("FAIL fill_level got=%h want=0800", rd); end
                csr(ADATA, MNONE, 32'h0, rd, v);
                total++; if (rd !== 32'h300) begin bad++; $display("FAIL fill_full got=%h want=300", rd); end
                csr(ADATA, MWR, 32'hAA, rd, v);
                csr(ASTAT, MNONE, 32'h0, rd, v);
                total++; if (rd !== 32'h0800) begin bad++; $display("FAIL fill_drop got=%h want=0800", rd); end
            end
            capture_tx(920, found);
        join
        total++;
        if (!found) begin
            bad++; $display("FAIL fill_start got=no start want=start bit");
        end else begin
            // Nine frames of bytes 1..9 must abut exactly, then the line stays idle.
            for (int k = 0; k < 9; k++) begin
                logic [9:0] fr;
                logic ok;
                logic [7:0] b;
                b = 8'(k + 1);
                fr = {1'b1, b, 1'b0};
                ok = 1'b1;
                for (int n = 0; n < 100; n++) if (tx_samp[k*100+n] !== fr[n/10]) ok = 1'b0;
                total++;
                if (!ok) begin bad++; $display("FAIL fill_frame%0d got=mismatch want=byte %h", k, b); end
            end
            begin
                logic ok;
                ok = 1'b1;
                for (int n = 900; n < 920; n++) if (tx_samp[n] !== 1'b1) ok = 1'b0;
                total++;
                if (!ok) begin bad++; $display("FAIL fill_idle got=low want=high"); end
            end
        end
        csr(ASTAT, MNONE, 32'h0, rd, v);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL fill_drained got=%h want=0", rd); end
    endtask

    task automatic test_rx();
        logic [31:0] rd;
        logic v;
        csr(ACTRL, MSET, 32'h0001_0000, rd, v);
        csr(ACTRL, MNONE, 32'h0, rd, v);
        total++; if (rd !== 32'h1_0009) begin bad++; $display("FAIL rx_ctrl got=%h want=10009", rd); end
        total++; if (irq_rx_o !== 1'b0) begin bad++; $display("FAIL rx_irq_idle got=%b want=0", irq_rx_o); end
        rx_send(8'hA3, 1'b1, 10);
        repeat (2) @(negedge clk);
        total++; if (irq_rx_o !== 1'b1) begin bad++; $display("FAIL rx_irq got=%b want=1", irq_rx_o); end
        csr(ADATA, MNONE, 32'h0, rd, v);
        total++; if (rd !== 32'h0A3) begin bad++; $display("FAIL rx_data got=%h want=0a3", rd); end
        csr(ADATA, MSET, 32'h0, rd, v);
        csr(ADATA, MNONE, 32'h0, rd, v);
        total++; if (rd !== 32'h100) begin bad++; $display("FAIL rx_popped got=%h want=100", rd); end
        total++; if (irq_rx_o !== 1'b0) begin bad++; $display("FAIL rx_irq_clr got=%b want=0", irq_rx_o); end
    endtask

    task automatic test_overrun();
        logic [31:0] rd;
        logic v;
        for (int i = 0; i < 9; i++) rx_send(8'(8'h10 + i), 1'b1, 10);
        repeat (2) @(negedge clk);
        csr(ASTAT, MNONE, 32'h0, rd, v);
        total++; if (rd !== 32'h0008) begin bad++; $display("FAIL ovr_level got=%h want=0008", rd); end
        csr(ADATA, MNONE, 32'h0, rd, v);
        total++; if (rd !== 32'h410) begin bad++; $display("FAIL ovr_flag got=%h want=410", rd); end
        for (int i = 0; i < 8; i++) begin
            logic [31:0] exp;
            exp = 32'h410 + i;
            csr(ADATA, MSET, 32'h0, rd, v);
            total++; if (rd !== exp) begin bad++; $display("FAIL ovr_pop%0d got=%h want=%h", i, rd, exp); end
        end
        csr(ADATA, MNONE, 32'h0, rd, v);
        total++; if (rd !== 32'h500) begin bad++; $display("FAIL ovr_empty got=%h want=500", rd); end
        csr(ADATA, MCLR, 32'h0, rd, v);
        csr(ADATA, MNONE, 32'h0, rd, v);
        total++; if (rd !== 32'h100) begin bad++; $display("FAIL ovr_clear got=%h want=100", rd); end
    endtask

    task automatic test_rx_errors();
        logic [31:0] rd;
        logic v;
        @(negedge clk);
        rx_i = 1'b0;
        repeat (3) @(negedge clk);
        rx_i = 1'b1;
        repeat (30) @(negedge clk);
        csr(ASTAT, MNONE, 32'h0, rd, v);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL glitch_level got=%h want=0", rd); end
        csr(ADATA, MNONE, 32'h0, rd, v);
        total++; if (rd !== 32'h100) begin bad++; $display("FAIL glitch_data got=%h want=100", rd); end
        rx_send(8'h5C, 1'b0, 10);
        repeat (20) @(negedge clk);
        csr(ADATA, MNONE, 32'h0, rd, v);
        total++; if (rd !== 32'h85C) begin bad++; $display("FAIL ferr_data got=%h want=85c", rd); end
        csr(ASTAT, MNONE, 32'h0, rd, v);
        total++; if (rd !== 32'h0001) begin bad++; $display("FAIL ferr_level got=%h want=0001", rd); end
        csr(ADATA, MSET, 32'h0, rd, v);
        csr(ADATA, MCLR, 32'h0, rd, v);
        csr(ADATA, MNONE, 32'h0, rd, v);
        total++; if (rd !== 32'h100) begin bad++; $display("FAIL ferr_clear got=%h want=100", rd); end
        csr(ACTRL, MCLR, 32'h0001_0000, rd, v);
        csr(ACTRL, MNONE, 32'h0, rd, v);
        total++; if (rd !== 32'h9) begin bad++; $display("FAIL ctrl_clr got=%h want=9", rd); end
    endtask

    task automatic test_div_and_reset();
        logic [31:0] rd;
        logic v;
        bit found;
        logic [10:0] fr;
        int per;
        for (int pass = 0; pass < 2; pass++) begin
            logic [31:0] dv;
            dv  = (pass == 0) ? 32'd4 : 32'd1;
            per = (pass == 0) ? 5 : 4;
            fr  = (pass == 0) ? {1'b1, 1'b1, 8'h55, 1'b0} : {1'b1, 1'b1, 8'hC6, 1'b0};
            csr(ACTRL, MWR, dv, rd, v);
            csr(ACTRL, MNONE, 32'h0, rd, v);
            total++; if (rd !== dv) begin bad++; $display("FAIL div_ctrl%0d got=%h want=%h", pass, rd, dv); end
            csr(ADATA, MWR, {23'b0, fr[8:1]}, rd, v);
            capture_tx(11 * per, found);
            begin
                logic ok;
                ok = found;
                if (found) begin
                    for (int n = 0; n < 11 * per; n++) if (tx_samp[n] !== fr[n/per]) ok = 1'b0;
                end
                total++;
                if (!ok) begin bad++; $display("FAIL div_frame%0d got=mismatch want=%0d cyc/bit", pass, per); end
            end
        end
        csr(ADATA, MWR, 32'h0F, rd, v);
        csr(ADATA, MWR, 32'hF0, rd, v);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (tx_o === 1'b0) begin found = 1'b1; break; end
            @(negedge clk);
        end
        total++; if (!found) begin bad++; $display("FAIL rst_start got=no start want=start bit"); end
        repeat (6) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        total++; if (tx_o !== 1'b1) begin bad++; $display("FAIL rst_tx got=%b want=1", tx_o); end
        @(negedge clk);
        rstn = 1'b1;
        csr(ASTAT, MNONE, 32'h0, rd, v);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL rst_status got=%h want=0", rd); end
        csr(ACTRL, MNONE, 32'h0, rd, v);
        total++; if (rd !== 32'h9) begin bad++; $display("FAIL rst_ctrl got=%h want=9", rd); end
        begin
            int lows;
            lows = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (tx_o !== 1'b1) lows++;
            end
            total++; if (lows != 0) begin bad++; $display("FAIL rst_idle got=%0d low cycles want=0", lows); end
        end
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_tx_fill();
        test_rx();
        test_overrun();
        test_rx_errors();
        test_div_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
